seg7_scan_n: RTL

SEG7_SCAN_N -- requirements
Module: seg7_scan_n

---
 rtl/seg7_scan_n.sv | 116 +++++++++++
 1 files changed

// File: rtl/seg7_scan_n.sv
// Multiplexed 7-segment scanner. Digits are latched into shadow registers on
// load and scanned one at a time. Each digit is held for SCAN_DIV clocks, with
// optional leading-zero blanking. Segment and select outputs are registered
// together so they always change on the same edge.
module seg7_scan_n #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 1000,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     scan_select,
  output logic [7:0]            seg7,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0]     LAST_IDX = IW'(DIGITS - 1);
  localparam logic [PW-1:0]     LAST_PRE = PW'(SCAN_DIV - 1);
  // XOR mask turning a one-hot select into the configured polarity
  localparam logic [DIGITS-1:0] SEL_POL  = {DIGITS{SEL_ACTIVE_LOW}};

  logic [4*DIGITS-1:0] shadow_num_q;
  logic [DIGITS-1:0]   shadow_dp_q;
  logic [PW-1:0]       pre_q;
  logic [IW-1:0]       idx_q, idx_d;
  logic [7:0]          seg7_q, seg7_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                fd_q;
  logic                tc;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h7E;  4'h1: hex7 = 7'h30;  4'h2: hex7 = 7'h6D;  4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33;  4'h5: hex7 = 7'h5B;  4'h6: hex7 = 7'h5F;  4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h7B;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E;  4'hD: hex7 = 7'h3D;  4'hE: hex7 = 7'h4F;  default: hex7 = 7'h47;
    endcase
  endfunction

  // Build the pattern/select for the digit about to be entered (idx_d),
  // always from the shadow values as they stand before this edge.
  always_comb begin
    logic [3:0]        digit;
    logic              dp;
    logic              lead_zero;
    logic              blank;
    logic [DIGITS-1:0] onehot;
    tc        = (pre_q == LAST_PRE);
    idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    digit     = 4'h0;
    dp        = 1'b0;
    lead_zero = 1'b1;
    blank     = 1'b0;
    onehot    = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == idx_d) begin
        digit     = shadow_num_q[4*k +: 4];
        dp        = shadow_dp_q[k];
        onehot[k] = 1'b1;
      end
    end
    // Walk down from the top digit; a digit is a leading zero while every
    // digit from the top down to it is zero. Digit 0 is never visited.
    for (int k = DIGITS - 1; k >= 1; k--) begin
      lead_zero = lead_zero & (shadow_num_q[4*k +: 4] == 4'h0);
      if (IW'(k) == idx_d) blank = lead_zero;
    end
    blank  = blank & blank_lz;
    seg7_d = {dp, blank ? 7'h00 : hex7(digit)};
    sel_d  = onehot ^ SEL_POL;
  end

  // Shadow capture of the display value
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_num_q <= '0;
      shadow_dp_q  <= '0;
    end else if (load) begin
      shadow_num_q <= num;
      shadow_dp_q  <= dp_in;
    end
  end

  // Prescaler, digit index and registered outputs, all advancing on TC
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      idx_q  <= LAST_IDX;
      seg7_q <= 8'h00;
      sel_q  <= SEL_POL;
      fd_q   <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (tc) begin
        pre_q  <= '0;
        idx_q  <= idx_d;
        seg7_q <= seg7_d;
        sel_q  <= sel_d;
        fd_q   <= (idx_d == '0);
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  assign seg7        = seg7_q;
  assign scan_select = sel_q;
  assign frame_done  = fd_q;

endmodule
